key_debounce: RTL and testbench

- Upstream conditioning stage for the two-digit push-button counter.
- Takes the raw, active-low board keys KEY0 and KEY2, synchronises and debounces each one, and emits a one-cycle pulse per accepted press.
- key0_pulse and key2_pulse drive the counter's Key_0 and Key_2 inputs directly. The debounced levels are also exported for status LEDs.

---
 rtl/key_debounce.sv | 162 ++++++++++++++++
 tb/tb_key_debounce.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Two-channel push-button synchroniser and debouncer emitting one-cycle press pulses and debounced levels.
// Optional auto-repeat while a key is held is compiled in with `define KEY_DEBOUNCE_AUTO_REPEAT_EN.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic Key_0,
  input  logic Key_2,
  output logic key0_pulse,
  output logic key2_pulse,
  output logic key0_level,
  output logic key2_level
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("key_debounce: invalid parameter set");
  end

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
`endif

  logic [1:0] raw;
  logic [1:0] pulse;
  logic [1:0] level;

  assign raw        = {Key_2, Key_0};
  assign key0_pulse = pulse[0];
  assign key2_pulse = pulse[1];
  assign key0_level = level[0];
  assign key2_level = level[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s1, s2;
    logic             pressed;
    logic             pulse_r, pulse_nxt;
    logic             level_r, level_nxt;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    logic [RPT_W-1:0] rpt, rpt_nxt;
    logic             rpt_late, rpt_late_nxt;  // first repeat already issued: use RATE period
`endif

    assign pressed  = ~s2;
    assign pulse[g] = pulse_r;
    assign level[g] = level_r;

    always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pulse_nxt    = 1'b0;
      level_nxt    = level_r;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
      rpt_nxt      = rpt;
      rpt_late_nxt = rpt_late;
`endif
      case (state)
        IDLE: begin
          cnt_nxt = '0;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
          rpt_nxt      = '0;
          rpt_late_nxt = 1'b0;
`endif
          if (pressed) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            pulse_nxt = 1'b1;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            rpt_nxt      = '0;
            rpt_late_nxt = 1'b0;
`endif
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_nxt = REL_CHK;
            cnt_nxt   = CNT_W'(1);
          end else begin
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            if (rpt == (rpt_late ? RPT_RATE_LAST : RPT_DELAY_LAST)) begin
              pulse_nxt    = 1'b1;
              rpt_nxt      = '0;
              rpt_late_nxt = 1'b1;
            end else begin
              rpt_nxt = rpt + RPT_W'(1);
            end
`endif
          end
        end
        REL_CHK: begin
          // Repeat counter is deliberately left untouched here so a bounce resumes it.
          if (pressed) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1       <= 1'b1;
        s2       <= 1'b1;
        state    <= IDLE;
        cnt      <= '0;
        pulse_r  <= 1'b0;
        level_r  <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
        rpt      <= '0;
        rpt_late <= 1'b0;
`endif
      end else begin
        s1       <= raw[g];
        s2       <= s1;
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        pulse_r  <= pulse_nxt;
        level_r  <= level_nxt;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
        rpt      <= rpt_nxt;
        rpt_late <= rpt_late_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5).
// Repeat-pulse expectations follow KEY_DEBOUNCE_AUTO_REPEAT_EN when it is defined for the build.
module tb_key_debounce;
  localparam int DC = 4;
  localparam int CW = 3;
  localparam int RD = 10;
  localparam int RR = 5;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic Key_0, Key_2;
  logic key0_pulse, key2_pulse, key0_level, key2_level;

  int n_assert = 0;
  int n_fail   = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Key_0(Key_0),
    .Key_2(Key_2),
    .key0_pulse(key0_pulse),
    .key2_pulse(key2_pulse),
    .key0_level(key0_level),
    .key2_level(key2_level)
  );

  always #5 clk = ~clk;

  // Pulse expected k edges after acceptance while the key is still seen as held.
  function automatic bit rpt_exp(input int k);
    return (k == 0) || (AR && k >= RD && ((k - RD) % RR) == 0);
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p0, input logic p2,
                         input logic l0, input logic l2);
    chk({tag, "/key0_pulse"}, key0_pulse, p0);
    chk({tag, "/key2_pulse"}, key2_pulse, p2);
    chk({tag, "/key0_level"}, key0_level, l0);
    chk({tag, "/key2_level"}, key2_level, l2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic p0, input logic p2,
                     input logic l0, input logic l2);
    step();
    chk_all(tag, p0, p2, l0, l2);
  endtask

  initial begin
    logic pat [7];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // 1: reset held while keys toggle, then release with keys high
    rst = 1'b0; Key_0 = 1'b1; Key_2 = 1'b1;
    #1;
    chk_all("t1_init", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      Key_0 = (i % 2 == 0) ? 1'b0 : 1'b1;
      Key_2 = (i % 3 == 0) ? 1'b0 : 1'b1;
      cyc($sformatf("t1_inrst%0d", i), 0, 0, 0, 0);
    end
    Key_0 = 1'b1; Key_2 = 1'b1;
    cyc("t1_inrst_last", 0, 0, 0, 0);
    rst = 1'b1;
    for (int s = 1; s <= 8; s++) cyc($sformatf("t1_idle%0d", s), 0, 0, 0, 0);

    // 2: Key_0 held low for 20 cycles, then released
    for (int s = 1; s <= 20; s++) begin
      Key_0 = 1'b0;
      cyc($sformatf("t2_hold%0d", s), (s >= 6) && rpt_exp(s - 6), 0, s >= 6, 0);
    end
    for (int s = 1; s <= 8; s++) begin
      Key_0 = 1'b1;
      cyc($sformatf("t2_rel%0d", s), (s <= 2) && rpt_exp(20 - 6 + s), 0, s <= 5, 0);
    end

    // 3: bouncing Key_2 is rejected, then a clean 5-cycle low is accepted
    for (int i = 0; i < 7; i++) begin
      Key_2 = pat[i];
      cyc($sformatf("t3_bounce%0d", i), 0, 0, 0, 0);
    end
    Key_2 = 1'b1;
    for (int s = 1; s <= 6; s++) cyc($sformatf("t3_quiet%0d", s), 0, 0, 0, 0);
    for (int s = 1; s <= 12; s++) begin
      Key_2 = (s <= 5) ? 1'b0 : 1'b1;
      cyc($sformatf("t3_clean%0d", s), 0, s == 6, 0, (s >= 6) && (s <= 10));
    end

    // 4: both keys fall on the same edge, then both released for 10 cycles
    for (int s = 1; s <= 8; s++) begin
      Key_0 = 1'b0; Key_2 = 1'b0;
      cyc($sformatf("t4_both%0d", s), (s >= 6) && rpt_exp(s - 6),
          (s >= 6) && rpt_exp(s - 6), s >= 6, s >= 6);
    end
    for (int s = 1; s <= 10; s++) begin
      Key_0 = 1'b1; Key_2 = 1'b1;
      cyc($sformatf("t4_rel%0d", s), 0, 0, s <= 5, s <= 5);
    end

    // 5: reset pulsed mid-press; the held key is re-debounced afterwards
    for (int s = 1; s <= 7; s++) begin
      Key_0 = 1'b0;
      cyc($sformatf("t5_press%0d", s), s == 6, 0, s >= 6, 0);
    end
    rst = 1'b0;
    #1;
    chk_all("t5_async_clr", 0, 0, 0, 0);
    cyc("t5_in_rst", 0, 0, 0, 0);
    rst = 1'b1;
    for (int s = 1; s <= 8; s++) cyc($sformatf("t5_redo%0d", s), s == 6, 0, s >= 6, 0);
    for (int s = 1; s <= 6; s++) begin
      Key_0 = 1'b1;
      cyc($sformatf("t5_rel%0d", s), 0, 0, s <= 5, 0);
    end

    // 6: long hold; released so the release is seen before a sixth repeat slot
    for (int s = 1; s <= 32; s++) begin
      Key_0 = 1'b0;
      cyc($sformatf("t6_hold%0d", s), (s >= 6) && rpt_exp(s - 6), 0, s >= 6, 0);
    end
    for (int s = 1; s <= 16; s++) begin
      Key_0 = 1'b1;
      cyc($sformatf("t6_rel%0d", s), (s <= 2) && rpt_exp(32 - 6 + s), 0, s <= 5, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
